// File: rtl/otter_hazard_ctrl.sv
// rtl/otter_hazard_ctrl.sv - OTTER pipeline hazard controller (load-use bubble, branch flush, dmem stall)
// Optional macro HAZ_PERF_CNT_EN adds o_stall_cnt / o_flush_cnt performance counters.
module otter_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_regwrite,
  input  logic        i_ex_memread,
  input  logic        i_br_taken,
  input  logic        i_dmem_busy,
  output logic        o_pc_we,
  output logic        o_if_id_we,
  output logic        o_id_ex_we,
  output logic        o_ex_mem_we,
  output logic        o_mem_wb_we,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_ld_haz,
  output logic        o_timeout_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_FWD   = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           r_ret;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ld_haz;
  logic             r_timeout_err;

  state_t           w_nxt_state;
  state_t           w_nxt_ret;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_ldu;
  logic             w_decode;
  logic             w_br_flush;
  logic [4:0]       w_we;     // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [1:0]       w_flush;  // {if_id, id_ex}

  assign w_ldu = i_ex_memread & i_ex_regwrite & (i_ex_rd != 5'd0) &
                 ((i_id_rs1_used & (i_ex_rd == i_id_rs1)) |
                  (i_id_rs2_used & (i_ex_rd == i_id_rs2)));

  always_comb begin
    w_we        = 5'b00000;
    w_flush     = 2'b00;
    w_nxt_state = r_state;
    w_nxt_ret   = r_ret;
    w_decode    = 1'b0;
    w_br_flush  = 1'b0;
    case (r_state)
      ST_RUN, ST_LD_FWD: begin
        if (i_dmem_busy) begin
          w_nxt_state = ST_MEM_WAIT;
          w_nxt_ret   = r_state;
        end else begin
          w_decode = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!i_dmem_busy) begin
          w_decode = 1'b1;
        end
      end
      default: w_nxt_state = ST_RUN;
    endcase
    if (w_decode) begin
      if (i_br_taken) begin
        w_we        = 5'b11111;
        w_flush     = 2'b11;
        w_nxt_state = ST_RUN;
        w_br_flush  = 1'b1;
      end else if (w_ldu) begin
        w_we        = 5'b00111;
        w_flush     = 2'b01;
        w_nxt_state = ST_LD_FWD;
      end else begin
        w_we        = 5'b11111;
        // A plain release resumes the interrupted state so a pending LD_FWD is not lost
        w_nxt_state = (r_state == ST_MEM_WAIT) ? r_ret : ST_RUN;
      end
    end
    if (!i_rst_n) begin
      w_we    = 5'b00000;
      w_flush = 2'b11;
    end
  end

  always_comb begin
    w_nxt_cnt = '0;
    if (r_state != ST_MEM_WAIT) begin
      w_nxt_cnt = i_dmem_busy ? CNT_W'(1) : '0;
    end else if (i_dmem_busy) begin
      w_nxt_cnt = (r_cnt == LP_TMO) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_RUN;
      r_ret         <= ST_RUN;
      r_cnt         <= '0;
      r_ld_haz      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_ret    <= w_nxt_ret;
      r_cnt    <= w_nxt_cnt;
      r_ld_haz <= (w_nxt_state == ST_LD_FWD) ||
                  ((w_nxt_state == ST_MEM_WAIT) && (w_nxt_ret == ST_LD_FWD));
      if (w_nxt_cnt == LP_TMO) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_pc_we       = w_we[4];
  assign o_if_id_we    = w_we[3];
  assign o_id_ex_we    = w_we[2];
  assign o_ex_mem_we   = w_we[1];
  assign o_mem_wb_we   = w_we[0];
  assign o_if_id_flush = w_flush[1];
  assign o_id_ex_flush = w_flush[0];
  assign o_ld_haz      = r_ld_haz;
  assign o_timeout_err = r_timeout_err;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_we[4]) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_br_flush) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// tb/tb_otter_hazard_ctrl.sv - directed scoreboard bench for otter_hazard_ctrl (MEM_TIMEOUT=4)
module tb_otter_hazard_ctrl;

  typedef struct {
    logic [4:0] we;
    logic [1:0] fl;
    logic       ld;
    logic       err;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       u1 = 0, u2 = 0, rw = 0, mr = 0, br = 0, busy = 0;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic       if_id_flush, id_ex_flush, ld_haz, timeout_err;
  logic [4:0] we_vec;
  logic [1:0] fl_vec;
  int         total = 0;
  int         bad = 0;
  exp_t       sb[$];
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] exp_stall = 0, exp_flush = 0;
`endif

  always #5 clk = ~clk;

  otter_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(u1), .i_id_rs2_used(u2),
    .i_ex_rd(ex_rd), .i_ex_regwrite(rw), .i_ex_memread(mr),
    .i_br_taken(br), .i_dmem_busy(busy),
    .o_pc_we(pc_we), .o_if_id_we(if_id_we), .o_id_ex_we(id_ex_we),
    .o_ex_mem_we(ex_mem_we), .o_mem_wb_we(mem_wb_we),
    .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_ld_haz(ld_haz), .o_timeout_err(timeout_err)
`ifdef HAZ_PERF_CNT_EN
    , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
`endif
  );

  assign we_vec = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we};
  assign fl_vec = {if_id_flush, id_ex_flush};

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; u1 = 0; u2 = 0;
    ex_rd = 5'd0; rw = 0; mr = 0; br = 0; busy = 0;
  endtask

  task automatic load_dep();
    idle();
    ex_rd = 5'd5; rw = 1; mr = 1; id_rs1 = 5'd5; u1 = 1;
  endtask

  task automatic push(input logic [4:0] we, input logic [1:0] fl, input logic ld,
                      input logic err, input string tag);
    exp_t e;
    e.we = we; e.fl = fl; e.ld = ld; e.err = err; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (we_vec === e.we) else begin
      bad++; $error("FAIL %s we got=%b exp=%b", e.tag, we_vec, e.we);
    end
    total++;
    assert (fl_vec === e.fl) else begin
      bad++; $error("FAIL %s flush got=%b exp=%b", e.tag, fl_vec, e.fl);
    end
    total++;
    assert (ld_haz === e.ld) else begin
      bad++; $error("FAIL %s ld_haz got=%b exp=%b", e.tag, ld_haz, e.ld);
    end
    total++;
    assert (timeout_err === e.err) else begin
      bad++; $error("FAIL %s timeout_err got=%b exp=%b", e.tag, timeout_err, e.err);
    end
`ifdef HAZ_PERF_CNT_EN
    if (rst_n && !e.we[4]) exp_stall++;
    if (rst_n && br && e.fl == 2'b11) exp_flush++;
`endif
  endtask

  task automatic cyc(input logic [4:0] we, input logic [1:0] fl, input logic ld,
                     input logic err, input string tag);
    push(we, fl, ld, err, tag);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
`ifdef HAZ_PERF_CNT_EN
    total++;
    assert (stall_cnt === exp_stall) else begin
      bad++; $error("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt, exp_stall);
    end
    total++;
    assert (flush_cnt === exp_flush) else begin
      bad++; $error("FAIL %s flush_cnt got=%0d exp=%0d", tag, flush_cnt, exp_flush);
    end
`endif
  endtask

  initial begin
    idle();
    #3;
    push(5'b00000, 2'b11, 0, 0, "reset");
    check_now();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    idle();                         cyc(5'b11111, 2'b00, 0, 0, "advance");
    load_dep();                     cyc(5'b00111, 2'b01, 0, 0, "ldu_bubble");
    idle();                         cyc(5'b11111, 2'b00, 1, 0, "ld_fwd");
    idle();                         cyc(5'b11111, 2'b00, 0, 0, "ld_fwd_end");
    load_dep(); ex_rd = 5'd0; id_rs1 = 5'd0;
                                    cyc(5'b11111, 2'b00, 0, 0, "rd_x0");
    load_dep(); id_rs1 = 5'd3; id_rs2 = 5'd5; u2 = 0;
                                    cyc(5'b11111, 2'b00, 0, 0, "rs2_unused");
    idle();                         cyc(5'b11111, 2'b00, 0, 0, "no_ld_haz");
    load_dep(); br = 1;             cyc(5'b11111, 2'b11, 0, 0, "ldu_and_br");
    idle();                         cyc(5'b11111, 2'b00, 0, 0, "after_br");

    load_dep();                     cyc(5'b00111, 2'b01, 0, 0, "ldu_pre_stall");
    idle(); busy = 1;               cyc(5'b00000, 2'b00, 1, 0, "stall_ldfwd_1");
    idle(); busy = 1;               cyc(5'b00000, 2'b00, 1, 0, "stall_ldfwd_2");
    idle(); busy = 1;               cyc(5'b00000, 2'b00, 1, 0, "stall_ldfwd_3");
    idle();                         cyc(5'b11111, 2'b00, 1, 0, "stall_release");
    idle();                         cyc(5'b11111, 2'b00, 1, 0, "back_ld_fwd");
    idle();                         cyc(5'b11111, 2'b00, 0, 0, "back_run");

    load_dep();                     cyc(5'b00111, 2'b01, 0, 0, "b2b_ld_1");
    load_dep();                     cyc(5'b00111, 2'b01, 1, 0, "b2b_ld_2");
    idle();                         cyc(5'b11111, 2'b00, 1, 0, "b2b_fwd");
    idle();                         cyc(5'b11111, 2'b00, 0, 0, "b2b_end");

    for (int i = 1; i <= 6; i++) begin
      idle(); busy = 1;
      cyc(5'b00000, 2'b00, 0, (i >= 5) ? 1'b1 : 1'b0, $sformatf("tmo_wait_%0d", i));
    end
    idle();                         cyc(5'b11111, 2'b00, 0, 1, "tmo_sticky");
    idle(); br = 1;                 cyc(5'b11111, 2'b11, 0, 1, "br_after_tmo");
    load_dep();                     cyc(5'b00111, 2'b01, 0, 1, "ldu_pre_rst");
    idle(); busy = 1;               cyc(5'b00000, 2'b00, 1, 1, "stall_pre_rst");

    rst_n = 0;
    push(5'b00000, 2'b11, 0, 0, "async_reset");
    #2;
    check_now();
`ifdef HAZ_PERF_CNT_EN
    exp_stall = 0; exp_flush = 0;
`endif
    idle();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    load_dep();                     cyc(5'b00111, 2'b01, 0, 0, "post_rst_ldu");
    idle();                         cyc(5'b11111, 2'b00, 1, 0, "post_rst_fwd");
    idle();                         cyc(5'b11111, 2'b00, 0, 0, "post_rst_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_hazard_ctrl.md
Name: otter_hazard_ctrl

Overview:
Pipeline hazard controller for the OTTER core. It sequences the stage-register enables and flushes, inserts the one-cycle load-use bubble, and drives LD_HAZ into the forwarding unit. It also freezes the whole pipeline while data memory is busy and flushes on taken branches. It sits beside the forwarding unit, between decode/execute control and the pipeline registers.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before TIMEOUT_ERR is set; legal range 2..65535.
CNT_W, 16, width of the MEM_WAIT cycle counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
CLK  in  1  core clock, rising edge
RST_N  in  1  asynchronous active-low reset
ID_RS1, ID_RS2  in  5 each  source register addresses of the instruction in ID
ID_RS1_USED, ID_RS2_USED  in  1 each  ID instruction actually reads rs1/rs2
EX_RD  in  5  destination register of the instruction in EX
EX_REGWRITE  in  1  EX instruction writes the register file
EX_MEMREAD  in  1  EX instruction is a load
BR_TAKEN  in  1  branch/jump resolved taken in EX this cycle
DMEM_BUSY  in  1  data memory has not completed the access in MEM
PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE  out  1 each  stage-register / PC write enables
IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  load a bubble into that register on this edge
LD_HAZ  out  1  to forwarding unit: consumer in EX takes load data from MEM/WB
TIMEOUT_ERR  out  1  sticky memory-timeout flag

Behaviour:
- ldu (comb) = EX_MEMREAD & EX_REGWRITE & (EX_RD!=0) & ((ID_RS1_USED & EX_RD==ID_RS1) | (ID_RS2_USED & EX_RD==ID_RS2)).
- States: RUN, LD_FWD, MEM_WAIT. State, LD_HAZ, TIMEOUT_ERR and counter are registered. Enables and flushes are a combinational decode of state plus inputs.
- While RST_N=0 (async): state=RUN, counter=0, ret=RUN, LD_HAZ=0, TIMEOUT_ERR=0. All WE=0. Both FLUSH=1. The first edge after release operates normally from RUN.
- Priority each cycle in RUN/LD_FWD: DMEM_BUSY > BR_TAKEN > ldu > advance.
- DMEM_BUSY=1: all WE=0, flushes=0. Next state is MEM_WAIT; ret:=current state. Counter:=1.
- BR_TAKEN=1: all WE=1, IF_ID_FLUSH=ID_EX_FLUSH=1. Next state RUN. Branch overrides ldu, since the dependent instruction is squashed.
- ldu=1: PC_WE=IF_ID_WE=0, ID_EX_WE=1, ID_EX_FLUSH=1, EX_MEM_WE=MEM_WB_WE=1. Next state LD_FWD.
- advance: all WE=1, flushes=0. Next state RUN.
- LD_HAZ=1 exactly while state=LD_FWD, i.e. the cycle after the bubble, when the load is in MEM/WB and the consumer is in EX. Latency from ldu to LD_HAZ is 1 cycle.
- ldu again in LD_FWD (back-to-back loads) is handled as above and stays in LD_FWD.
- MEM_WAIT: all WE=0, flushes=0. BR_TAKEN and ldu are ignored because EX is frozen and they are re-presented.
  - Counter increments each cycle, saturating at MEM_TIMEOUT.
  - When counter reaches MEM_TIMEOUT, TIMEOUT_ERR:=1 and stays set until reset. The stall continues regardless.
  - When DMEM_BUSY=0: enables decode as in ret state's normal rules this cycle, next state=ret, counter:=0. LD_HAZ therefore resumes if the stall interrupted LD_FWD.
- LD_HAZ is held at 1 through MEM_WAIT when ret=LD_FWD, because the consumer stays in EX.
- Reset asserted mid-stall aborts immediately to reset values. No pending stall is remembered.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs STALL_CNT[31:0] and FLUSH_CNT[31:0], both reset to 0 asynchronously.
  - STALL_CNT increments on every cycle with PC_WE=0 outside reset.
  - FLUSH_CNT increments on every BR_TAKEN flush.
  - Both wrap at 2^32.
- Undefined: no counters or ports. All other behaviour is identical.

Test Plan:
- Load x5 in EX, ID add reads rs1=x5 (USED=1) -> cycle0: PC_WE=0, IF_ID_WE=0, ID_EX_FLUSH=1; cycle1: LD_HAZ=1, all WE=1; cycle2: LD_HAZ=0.
- Same as above but EX_RD=x0, or RS2 match with ID_RS2_USED=0 -> no stall, LD_HAZ stays 0.
- ldu and BR_TAKEN in the same cycle -> all WE=1, both FLUSH=1, state stays RUN, LD_HAZ=0 next cycle.
- DMEM_BUSY high 3 cycles during LD_FWD -> all WE=0 for 3 cycles, LD_HAZ=1 throughout, returns to LD_FWD then RUN; TIMEOUT_ERR=0.
- MEM_TIMEOUT=4, DMEM_BUSY held 6 cycles -> TIMEOUT_ERR rises on the 4th wait cycle and stays 1 after DMEM_BUSY drops, until RST_N=0.
- RST_N pulled low mid-MEM_WAIT -> outputs go to reset values immediately (async). After release, RUN behaviour is normal. With HAZ_PERF_CNT_EN, STALL_CNT=0 after reset and counts only stall cycles.
